// File: rtl/cube_pkg.sv
// Shared types and palette table for the cube shading stage.
// Palette entries are packed as {left, right, top, bg}, each 24-bit RGB.
package cube_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef struct packed {
      rgb_t left;
      rgb_t right;
      rgb_t top;
      rgb_t bg;
   } palette_t;

   typedef enum logic [1:0] {
      IDLE,
      PENDING,
      APPLY
   } state_t;

   // Scheme 0 keeps a black background so a freshly reset display stays dark.
   localparam palette_t PAL [4] = '{
      {24'hE03030, 24'h30E030, 24'hC8C840, 24'h000000},
      {24'h2040E0, 24'hE08020, 24'hF0F0F0, 24'h303030},
      {24'h80FF80, 24'h8080FF, 24'hFF8080, 24'h202020},
      {24'hFFFF00, 24'h00FFFF, 24'hFF00FF, 24'h404040}
   };

   function automatic rgb_t shade(input rgb_t c);
      rgb_t s;
      s.r = c.r - (c.r >> 3);
      s.g = c.g - (c.g >> 3);
      s.b = c.b - (c.b >> 3);
      return s;
   endfunction

   function automatic rgb_t invert(input rgb_t c);
      return rgb_t'(~c);
   endfunction

endpackage

// File: rtl/cube_shader_coord_delay.sv
// LAT-stage shift register re-aligning raster x/y counters to a delayed pixel stream.
// Clears to (0,0) on reset.
module coord_delay #(
   parameter int LAT = 1,
   parameter int XW  = 11,
   parameter int YW  = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [XW-1:0] i_x,
   input  logic [YW-1:0] i_y,
   output logic [XW-1:0] o_x,
   output logic [YW-1:0] o_y
);

   logic [XW-1:0] r_x [LAT];
   logic [YW-1:0] r_y [LAT];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < LAT; i++) begin
            r_x[i] <= '0;
            r_y[i] <= '0;
         end
      end else begin
         r_x[0] <= i_x;
         r_y[0] <= i_y;
         for (int i = 1; i < LAT; i++) begin
            r_x[i] <= r_x[i-1];
            r_y[i] <= r_y[i-1];
         end
      end
   end

   assign o_x = r_x[LAT-1];
   assign o_y = r_y[LAT-1];

endmodule

// File: rtl/cube_shader.sv
// Colours cube face masks from a palette, with frame-synchronous palette
// switching and an optional blink highlight. Reset input is active-low.
module cube_shader
   import cube_pkg::*;
#(
   parameter int H_ACTIVE     = 800,
   parameter int V_ACTIVE     = 480,
   parameter int FACE_LAT     = 1,
   parameter int BLINK_FRAMES = 30
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] x_cnt,
   input  logic [9:0]  y_cnt,
   input  logic        left_face,
   input  logic        right_face,
   input  logic [3:0]  top_face,
   input  logic        scheme_next,
   input  logic        highlight_en,
   output logic [7:0]  red,
   output logic [7:0]  green,
   output logic [7:0]  blue,
   output logic [1:0]  scheme,
   output logic        pending
);

   localparam logic [10:0] H_LIM      = 11'(H_ACTIVE);
   localparam logic [9:0]  V_LIM      = 10'(V_ACTIVE);
   localparam logic [7:0]  BLINK_LAST = 8'(BLINK_FRAMES - 1);

   logic [10:0] w_xa;
   logic [9:0]  w_ya;
   logic        w_active;
   logic        w_frameStart;
   logic [1:0]  w_palIdx;
   palette_t    w_pal;
   rgb_t        w_face;
   rgb_t        w_pix;
   logic        w_isFace;

   state_t      r_state;
   logic [1:0]  r_scheme;
   logic        r_pending;
   logic [7:0]  r_blinkCnt;
   logic        r_blinkOn;
   rgb_t        r_rgb;

   coord_delay #(
      .LAT (FACE_LAT),
      .XW  (11),
      .YW  (10)
   ) u_coordDelay (
      .clk   (clk),
      .rst_n (reset),
      .i_x   (x_cnt),
      .i_y   (y_cnt),
      .o_x   (w_xa),
      .o_y   (w_ya)
   );

   assign w_active     = (w_xa < H_LIM) && (w_ya < V_LIM);
   assign w_frameStart = (w_xa == '0) && (w_ya == '0);

   // During APPLY the scheme register has not stepped yet, but the pixel after
   // frame start must already use the new palette.
   assign w_palIdx = (r_state == APPLY) ? r_scheme + 2'd1 : r_scheme;
   assign w_pal    = PAL[w_palIdx];

   always_comb begin
      w_face   = w_pal.bg;
      w_isFace = 1'b1;
      if (left_face)
         w_face = w_pal.left;
      else if (right_face)
         w_face = w_pal.right;
      else if (top_face[0] | top_face[2])
         w_face = w_pal.top;
      else if (top_face[1] | top_face[3])
         w_face = shade(w_pal.top);
      else
         w_isFace = 1'b0;

      w_pix = '0;
      if (w_active)
         w_pix = (w_isFace && r_blinkOn && highlight_en) ? invert(w_face) : w_face;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_rgb <= '0;
      else
         r_rgb <= w_pix;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_scheme  <= 2'd0;
         r_pending <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (scheme_next) begin
                  r_state   <= PENDING;
                  r_pending <= 1'b1;
               end
            end
            PENDING: begin
               if (w_frameStart)
                  r_state <= APPLY;
            end
            APPLY: begin
               r_scheme  <= r_scheme + 2'd1;
               r_state   <= IDLE;
               r_pending <= 1'b0;
            end
            default: begin
               r_state   <= IDLE;
               r_pending <= 1'b0;
            end
         endcase
      end
   end

   // Blink phase flips every BLINK_FRAMES frame starts while highlighting.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_blinkCnt <= 8'd0;
         r_blinkOn  <= 1'b0;
      end else if (!highlight_en) begin
         r_blinkCnt <= 8'd0;
         r_blinkOn  <= 1'b0;
      end else if (w_frameStart) begin
         if (r_blinkCnt == BLINK_LAST) begin
            r_blinkCnt <= 8'd0;
            r_blinkOn  <= ~r_blinkOn;
         end else begin
            r_blinkCnt <= r_blinkCnt + 8'd1;
         end
      end
   end

   assign red     = r_rgb.r;
   assign green   = r_rgb.g;
   assign blue    = r_rgb.b;
   assign scheme  = r_scheme;
   assign pending = r_pending;

endmodule
